branch_cond_unit: RTL and testbench

Resolves conditional-branch decisions from the NZVC condition flags and sits directly downstream of the flag register stage. It accepts one branch request per cycle over a valid/ready handshake. It forwards the live ALU flags when a flag-setting instruction writes the flag register in the same cycle, and it registers the taken/not-taken result toward the PC-select logic. It also keeps saturating statistics counters for branch resolution.

---
 rtl/branch_cond_unit.sv | 193 +++++++++++++++++++
 tb/tb_branch_cond_unit.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_cond_unit.sv
// Resolves conditional branches from NZVC flags (with same-cycle ALU flag forwarding) and keeps resolution stats.
// Latency: 1 cycle from accepted request to registered out_valid/out_taken; counters lag the consume by 1 cycle.
// Backpressure: br_ready drops while a result is held and out_ready=0, or for B.cond while flags are pending.
//
// Ports:
//    clk, reset            clock; asynchronous active-low reset
//    Flags                 registered flags [0]=N [1]=Z [2]=V [3]=C
//    flag_we               flag-setting instruction writes Flags at the next edge
//    alu_neg/zero/ovf/cout live ALU flags, used in place of Flags when flag_we=1
//    flag_pending          flag-setting instruction still upstream of the ALU
//    br_valid/br_ready     request handshake
//    br_kind               00=B.cond 01=CBZ 10=CBNZ 11=B
//    br_cond               condition code (B.cond only)
//    br_reg_zero           compared register is zero (CBZ/CBNZ only)
//    out_valid/out_ready   result handshake
//    out_taken             registered branch decision
//    taken_cnt             saturating count of consumed taken results
//    resolved_cnt          saturating count of all consumed results
//    cnt_clr               synchronous clear of both counters (wins over increment)

module branch_cond_unit #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [3:0]       Flags,
   input  logic             flag_we,
   input  logic             alu_neg,
   input  logic             alu_zero,
   input  logic             alu_ovf,
   input  logic             alu_cout,
   input  logic             flag_pending,
   input  logic             br_valid,
   output logic             br_ready,
   input  logic [1:0]       br_kind,
   input  logic [3:0]       br_cond,
   input  logic             br_reg_zero,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             out_taken,
   output logic [CNT_W-1:0] taken_cnt,
   output logic [CNT_W-1:0] resolved_cnt,
   input  logic             cnt_clr
);

   localparam logic [1:0] KIND_BCOND = 2'b00;
   localparam logic [1:0] KIND_CBZ   = 2'b01;
   localparam logic [1:0] KIND_CBNZ  = 2'b10;
   localparam logic [1:0] KIND_B     = 2'b11;

   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   typedef enum logic {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } state_t;

   state_t state, state_nxt;
   logic   taken_q, taken_nxt;

   logic eff_n, eff_z, eff_v, eff_c;
   logic cond_base;
   logic cond_hit;
   logic result;
   logic accept;
   logic consume;
   logic flag_stall;

   // ---------------------------------------------------------------
   // Effective flags: a flag-setting instruction completing this cycle
   // has not reached Flags yet, so its live ALU flags are used instead.
   // ---------------------------------------------------------------
   always_comb begin
      eff_n = Flags[0];
      eff_z = Flags[1];
      eff_v = Flags[2];
      eff_c = Flags[3];
      if (flag_we) begin
         eff_n = alu_neg;
         eff_z = alu_zero;
         eff_v = alu_ovf;
         eff_c = alu_cout;
      end
   end

   // ---------------------------------------------------------------
   // Condition codes come in complementary pairs: cond[3:1] picks the
   // base test and cond[0] inverts it. Pair 7 (AL/NV) is always true
   // regardless of the low bit.
   // ---------------------------------------------------------------
   always_comb begin
      cond_base = 1'b0;
      unique case (br_cond[3:1])
         3'd0: cond_base = eff_z;                          // EQ / NE
         3'd1: cond_base = eff_c;                          // HS / LO
         3'd2: cond_base = eff_n;                          // MI / PL
         3'd3: cond_base = eff_v;                          // VS / VC
         3'd4: cond_base = eff_c & ~eff_z;                 // HI / LS
         3'd5: cond_base = (eff_n == eff_v);               // GE / LT
         3'd6: cond_base = ~eff_z & (eff_n == eff_v);      // GT / LE
         3'd7: cond_base = 1'b1;                           // AL / NV
         default: cond_base = 1'b0;
      endcase
      if (br_cond[3:1] == 3'd7) begin
         cond_hit = 1'b1;
      end else begin
         cond_hit = cond_base ^ br_cond[0];
      end
   end

   // Decision for the request currently presented.
   always_comb begin
      result = 1'b0;
      unique case (br_kind)
         KIND_BCOND: result = cond_hit;
         KIND_CBZ:   result = br_reg_zero;
         KIND_CBNZ:  result = ~br_reg_zero;
         KIND_B:     result = 1'b1;
         default:    result = 1'b0;
      endcase
   end

   // ---------------------------------------------------------------
   // Handshakes. Only B.cond depends on flags, so only B.cond waits on
   // an in-flight flag-setting instruction.
   // ---------------------------------------------------------------
   assign flag_stall = flag_pending & (br_kind == KIND_BCOND);
   assign out_valid  = (state == FULL);
   assign out_taken  = taken_q;
   assign br_ready   = (~out_valid | out_ready) & ~flag_stall;
   assign accept     = br_valid & br_ready;
   assign consume    = out_valid & out_ready;

   // ---------------------------------------------------------------
   // Result register FSM
   // ---------------------------------------------------------------
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state   <= EMPTY;
         taken_q <= 1'b0;
      end else begin
         state   <= state_nxt;
         taken_q <= taken_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      taken_nxt = taken_q;
      unique case (state)
         EMPTY: begin
            if (accept) begin
               state_nxt = FULL;
               taken_nxt = result;
            end
         end
         FULL: begin
            // In FULL an accept is only possible when out_ready=1, so an
            // accept here is always a consume-and-reload.
            if (accept) begin
               state_nxt = FULL;
               taken_nxt = result;
            end else if (consume) begin
               state_nxt = EMPTY;
            end
         end
         default: begin
            state_nxt = EMPTY;
         end
      endcase
   end

   // ---------------------------------------------------------------
   // Statistics counters: count consumed results, saturate at all-ones.
   // ---------------------------------------------------------------
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         taken_cnt    <= '0;
         resolved_cnt <= '0;
      end else if (cnt_clr) begin
         taken_cnt    <= '0;
         resolved_cnt <= '0;
      end else if (consume) begin
         if (!(&resolved_cnt)) begin
            resolved_cnt <= resolved_cnt + CNT_ONE;
         end
         if (taken_q && !(&taken_cnt)) begin
            taken_cnt <= taken_cnt + CNT_ONE;
         end
      end
   end

endmodule

// File: tb/tb_branch_cond_unit.sv
// Testbench for branch_cond_unit: directed scenarios with literal expectations
// plus randomized traffic, all compared every cycle against a behavioural model.
// The model tracks the held result and the counters as plain integers.

module tb_branch_cond_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic [3:0]  Flags;
   logic        flag_we;
   logic        alu_neg, alu_zero, alu_ovf, alu_cout;
   logic        flag_pending;
   logic        br_valid;
   logic        br_ready;
   logic [1:0]  br_kind;
   logic [3:0]  br_cond;
   logic        br_reg_zero;
   logic        out_valid;
   logic        out_ready;
   logic        out_taken;
   logic [15:0] taken_cnt;
   logic [15:0] resolved_cnt;
   logic        cnt_clr;

   int total = 0;
   int bad   = 0;

   branch_cond_unit #(.CNT_W(16)) dut (
      .clk          (clk),
      .reset        (reset),
      .Flags        (Flags),
      .flag_we      (flag_we),
      .alu_neg      (alu_neg),
      .alu_zero     (alu_zero),
      .alu_ovf      (alu_ovf),
      .alu_cout     (alu_cout),
      .flag_pending (flag_pending),
      .br_valid     (br_valid),
      .br_ready     (br_ready),
      .br_kind      (br_kind),
      .br_cond      (br_cond),
      .br_reg_zero  (br_reg_zero),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_taken    (out_taken),
      .taken_cnt    (taken_cnt),
      .resolved_cnt (resolved_cnt),
      .cnt_clr      (cnt_clr)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   function automatic bit model_taken(input logic [1:0] kind, input logic [3:0] cond,
                                      input logic regz, input logic [3:0] f);
      bit n, z, v, c;
      n = f[0]; z = f[1]; v = f[2]; c = f[3];
      case (kind)
         2'b01: return regz;
         2'b10: return !regz;
         2'b11: return 1'b1;
         default: begin
            case (cond)
               4'd0:  return z;
               4'd1:  return !z;
               4'd2:  return c;
               4'd3:  return !c;
               4'd4:  return n;
               4'd5:  return !n;
               4'd6:  return v;
               4'd7:  return !v;
               4'd8:  return c && !z;
               4'd9:  return !c || z;
               4'd10: return n == v;
               4'd11: return n != v;
               4'd12: return !z && (n == v);
               4'd13: return z || (n != v);
               default: return 1'b1;
            endcase
         end
      endcase
   endfunction

   bit m_valid = 0;
   bit m_taken = 0;
   int m_res   = 0;
   int m_tak   = 0;

   function automatic bit model_ready();
      return (!m_valid || out_ready) && !(flag_pending && br_kind == 2'b00);
   endfunction

   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         m_valid = 0; m_taken = 0; m_res = 0; m_tak = 0;
      end else begin
         bit consume, accept, res;
         logic [3:0] ef;
         consume = m_valid && out_ready;
         accept  = br_valid && model_ready();
         ef      = flag_we ? {alu_cout, alu_ovf, alu_zero, alu_neg} : Flags;
         res     = model_taken(br_kind, br_cond, br_reg_zero, ef);
         if (cnt_clr) begin
            m_res = 0; m_tak = 0;
         end else if (consume) begin
            if (m_res < 65535) m_res = m_res + 1;
            if (m_taken && m_tak < 65535) m_tak = m_tak + 1;
         end
         if (accept) begin
            m_valid = 1; m_taken = res;
         end else if (consume) begin
            m_valid = 0;
         end
      end
   end

   // ---------------- per-cycle compare ----------------
   always @(negedge clk) begin
      chk("cmp_br_ready", 32'(br_ready), 32'(model_ready()));
      chk("cmp_out_valid", 32'(out_valid), 32'(m_valid));
      if (m_valid) chk("cmp_out_taken", 32'(out_taken), 32'(m_taken));
      chk("cmp_resolved_cnt", 32'(resolved_cnt), 32'(m_res));
      chk("cmp_taken_cnt", 32'(taken_cnt), 32'(m_tak));
   end

   // ---------------- stimulus helpers ----------------
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic req(input logic [1:0] k, input logic [3:0] c, input logic z);
      br_valid = 1'b1; br_kind = k; br_cond = c; br_reg_zero = z;
   endtask

   task automatic idle();
      br_valid = 1'b0; br_kind = 2'b00; br_cond = 4'd0; br_reg_zero = 1'b0;
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish, time %0t", $time);
      $fatal(1, "watchdog");
   end

   logic [1:0] b2b_k [4] = '{2'b00, 2'b00, 2'b00, 2'b10};
   logic [3:0] b2b_c [4] = '{4'd12, 4'd11, 4'd14, 4'd0};
   logic       b2b_z [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
   int         b2b_e [4] = '{1, 0, 1, 0};

   initial begin
      reset = 1'b0;
      Flags = 4'b0010;
      flag_we = 1'b0; alu_neg = 1'b0; alu_zero = 1'b0; alu_ovf = 1'b0; alu_cout = 1'b0;
      flag_pending = 1'b0; out_ready = 1'b1; cnt_clr = 1'b0;
      idle();

      // Reset state
      repeat (2) @(negedge clk);
      chk("rst_out_valid", 32'(out_valid), 0);
      chk("rst_out_taken", 32'(out_taken), 0);
      chk("rst_taken_cnt", 32'(taken_cnt), 0);
      chk("rst_resolved_cnt", 32'(resolved_cnt), 0);
      chk("rst_br_ready", 32'(br_ready), 1);

      // EQ with Z=1 right after reset release
      @(posedge clk); #1;
      reset = 1'b1;
      req(2'b00, 4'd0, 1'b0);
      cyc(); idle();
      @(negedge clk);
      chk("eq_out_valid", 32'(out_valid), 1);
      chk("eq_out_taken", 32'(out_taken), 1);
      cyc();
      @(negedge clk);
      chk("eq_resolved_cnt", 32'(resolved_cnt), 1);
      chk("eq_taken_cnt", 32'(taken_cnt), 1);

      // Forwarding: live Z=1 overrides Flags Z=0 for NE
      cyc();
      Flags = 4'b0000; flag_we = 1'b1; alu_zero = 1'b1;
      req(2'b00, 4'd1, 1'b0);
      cyc(); idle(); flag_we = 1'b0; alu_zero = 1'b0;
      @(negedge clk);
      chk("fwd_ne_taken", 32'(out_taken), 0);
      cyc();
      alu_zero = 1'b1;
      req(2'b00, 4'd1, 1'b0);
      cyc(); idle(); alu_zero = 1'b0;
      @(negedge clk);
      chk("nofwd_ne_taken", 32'(out_taken), 1);

      // flag_pending stalls B.cond but not CBZ
      cyc();
      flag_pending = 1'b1;
      req(2'b00, 4'd10, 1'b0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("pend_br_ready", 32'(br_ready), 0);
         cyc();
      end
      req(2'b01, 4'd10, 1'b1);
      @(negedge clk);
      chk("pend_cbz_ready", 32'(br_ready), 1);
      cyc(); idle(); flag_pending = 1'b0;
      @(negedge clk);
      chk("pend_cbz_valid", 32'(out_valid), 1);
      chk("pend_cbz_taken", 32'(out_taken), 1);

      // Back-to-back: GT, LT, AL, CBNZ(zero) with N=Z=V=C=0
      cyc();
      cnt_clr = 1'b1;
      cyc();
      cnt_clr = 1'b0;
      Flags = 4'b0000;
      req(b2b_k[0], b2b_c[0], b2b_z[0]);
      cyc();
      for (int i = 1; i < 4; i++) begin
         req(b2b_k[i], b2b_c[i], b2b_z[i]);
         @(negedge clk);
         chk("b2b_taken", 32'(out_taken), 32'(b2b_e[i-1]));
         chk("b2b_valid", 32'(out_valid), 1);
         cyc();
      end
      idle();
      @(negedge clk);
      chk("b2b_taken", 32'(out_taken), 32'(b2b_e[3]));
      cyc();
      @(negedge clk);
      chk("b2b_taken_cnt", 32'(taken_cnt), 2);
      chk("b2b_resolved_cnt", 32'(resolved_cnt), 4);

      // Backpressure: held B result, waiting CBZ(not zero)
      cyc();
      out_ready = 1'b0;
      req(2'b11, 4'd0, 1'b0);
      cyc();
      req(2'b01, 4'd0, 1'b0);
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         chk("bp_valid", 32'(out_valid), 1);
         chk("bp_taken", 32'(out_taken), 1);
         chk("bp_br_ready", 32'(br_ready), 0);
         chk("bp_taken_cnt", 32'(taken_cnt), 2);
         chk("bp_resolved_cnt", 32'(resolved_cnt), 4);
         cyc();
      end
      out_ready = 1'b1;
      @(negedge clk);
      chk("bp_ready_rise", 32'(br_ready), 1);
      cyc(); idle();
      @(negedge clk);
      chk("bp_new_valid", 32'(out_valid), 1);
      chk("bp_new_taken", 32'(out_taken), 0);
      chk("bp_resolved_cnt2", 32'(resolved_cnt), 5);
      chk("bp_taken_cnt2", 32'(taken_cnt), 3);
      cyc();
      @(negedge clk);
      chk("bp_resolved_cnt3", 32'(resolved_cnt), 6);
      chk("bp_taken_cnt3", 32'(taken_cnt), 3);

      // Saturation after a long stream of taken branches
      cyc();
      cnt_clr = 1'b1;
      req(2'b11, 4'd0, 1'b0);
      cyc();
      cnt_clr = 1'b0;
      repeat (65540) cyc();
      @(negedge clk);
      chk("sat_resolved_cnt", 32'(resolved_cnt), 32'h0000ffff);
      chk("sat_taken_cnt", 32'(taken_cnt), 32'h0000ffff);
      cnt_clr = 1'b1;
      cyc();
      cnt_clr = 1'b0; idle();
      @(negedge clk);
      chk("clr_resolved_cnt", 32'(resolved_cnt), 0);
      chk("clr_taken_cnt", 32'(taken_cnt), 0);

      // Asynchronous reset while a result is held
      cyc();
      out_ready = 1'b0;
      req(2'b11, 4'd0, 1'b0);
      cyc(); idle();
      @(negedge clk);
      chk("arst_pre_valid", 32'(out_valid), 1);
      @(posedge clk); #2;
      reset = 1'b0;
      #1;
      chk("arst_out_valid", 32'(out_valid), 0);
      chk("arst_out_taken", 32'(out_taken), 0);
      chk("arst_resolved_cnt", 32'(resolved_cnt), 0);
      @(posedge clk); #1;
      reset = 1'b1; out_ready = 1'b1;

      // Randomized traffic, checked by the per-cycle compare
      repeat (3000) begin
         br_valid     = 1'($urandom_range(0, 1));
         br_kind      = 2'($urandom_range(0, 3));
         br_cond      = 4'($urandom_range(0, 15));
         br_reg_zero  = 1'($urandom_range(0, 1));
         Flags        = 4'($urandom_range(0, 15));
         alu_neg      = 1'($urandom_range(0, 1));
         alu_zero     = 1'($urandom_range(0, 1));
         alu_ovf      = 1'($urandom_range(0, 1));
         alu_cout     = 1'($urandom_range(0, 1));
         flag_we      = ($urandom_range(0, 3) == 0);
         flag_pending = !flag_we && ($urandom_range(0, 2) == 0);
         out_ready    = ($urandom_range(0, 9) < 7);
         cnt_clr      = ($urandom_range(0, 49) == 0);
         cyc();
      end
      idle();
      flag_we = 1'b0; flag_pending = 1'b0; cnt_clr = 1'b0; out_ready = 1'b1;
      repeat (3) cyc();
      @(negedge clk);
      #1;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
